// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue ahead of the LSU.
// Captures operands from the CDB and issues one op at a time in program order.
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 4
`endif
`ifndef ROB_IDX_WIDTH
`define ROB_IDX_WIDTH 5
`endif
`ifndef ROB_GEN_WIDTH
`define ROB_GEN_WIDTH 1
`endif

package mem_iq_pkg;
  typedef struct packed {
    logic                       valid;
    logic                       base_rdy;
    logic [`PREG_IDX_WIDTH-1:0] base_tag;
    logic [31:0]                base_val;
    logic                       data_rdy;
    logic [`PREG_IDX_WIDTH-1:0] data_tag;
    logic                       data_fp;
    logic [31:0]                data_val;
    logic [31:0]                imm;
    logic [`MEM_OP_WIDTH-1:0]   mem_op;
    logic                       is_load;
    logic                       uns;
    logic [`ROB_IDX_WIDTH-1:0]  rob_idx;
    logic [`ROB_GEN_WIDTH-1:0]  rob_gen;
    logic [`PREG_IDX_WIDTH-1:0] rd_tag;
    logic                       rd_fp;
  } iq_entry_t;
endpackage

module mem_issue_queue
  import mem_iq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_base_ready,
  input  logic [`PREG_IDX_WIDTH-1:0] enq_base_tag,
  input  logic [31:0]                enq_base_val,
  input  logic                       enq_data_ready,
  input  logic [`PREG_IDX_WIDTH-1:0] enq_data_tag,
  input  logic                       enq_data_is_fp,
  input  logic [31:0]                enq_data_val,
  input  logic [31:0]                enq_imm,
  input  logic [`MEM_OP_WIDTH-1:0]   enq_mem_op,
  input  logic                       enq_is_load,
  input  logic                       enq_unsigned,
  input  logic [`ROB_IDX_WIDTH-1:0]  enq_rob_idx,
  input  logic [`ROB_GEN_WIDTH-1:0]  enq_rob_gen,
  input  logic [`PREG_IDX_WIDTH-1:0] enq_rd_tag,
  input  logic                       enq_rd_is_fp,
  input  logic                       cdb_valid,
  input  logic [`PREG_IDX_WIDTH-1:0] cdb_tag,
  input  logic                       cdb_is_fp,
  input  logic [31:0]                cdb_value,
  input  logic                       lsu_busy,
  output logic                       iss_valid,
  output logic [31:0]                iss_addr,
  output logic [31:0]                iss_wdata,
  output logic [`MEM_OP_WIDTH-1:0]   iss_mem_op,
  output logic                       iss_is_load,
  output logic                       iss_unsigned,
  output logic [`ROB_IDX_WIDTH-1:0]  iss_rob_idx,
  output logic [`ROB_GEN_WIDTH-1:0]  iss_rob_gen,
  output logic [`PREG_IDX_WIDTH-1:0] iss_rd_tag,
  output logic                       iss_rd_is_fp,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t     q [DEPTH];
  iq_entry_t     new_e;
  iq_entry_t     hd;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          base_hit;
  logic          data_hit;
  logic          do_enq;
  logic          do_iss;

  assign count     = cnt;
  assign enq_ready = cnt < CW'(DEPTH);
  assign hd        = q[head];

  assign do_enq = enq_valid && enq_ready
               && !flush && !rst;
  assign do_iss = hd.valid && hd.base_rdy
               && (hd.data_rdy || hd.is_load)
               && !lsu_busy && !iss_valid
               && !flush && !rst;

  // Same-cycle CDB bypass so an enqueuing op cannot miss its producer.
  assign base_hit = !enq_base_ready && cdb_valid
                 && !cdb_is_fp
                 && cdb_tag == enq_base_tag;
  assign data_hit = !enq_data_ready && !enq_is_load
                 && cdb_valid
                 && cdb_is_fp == enq_data_is_fp
                 && cdb_tag == enq_data_tag;

  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.base_rdy = enq_base_ready | base_hit;
    new_e.base_tag = enq_base_tag;
    new_e.base_val = base_hit ? cdb_value
                              : enq_base_val;
    new_e.data_rdy = enq_data_ready | enq_is_load
                   | data_hit;
    new_e.data_tag = enq_data_tag;
    new_e.data_fp  = enq_data_is_fp;
    new_e.data_val = data_hit ? cdb_value
                              : enq_data_val;
    new_e.imm      = enq_imm;
    new_e.mem_op   = enq_mem_op;
    new_e.is_load  = enq_is_load;
    new_e.uns      = enq_unsigned;
    new_e.rob_idx  = enq_rob_idx;
    new_e.rob_gen  = enq_rob_gen;
    new_e.rd_tag   = enq_rd_tag;
    new_e.rd_fp    = enq_rd_is_fp;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++)
        q[i].valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      iss_valid <= 1'b0;
      if (rst) begin
        iss_addr     <= '0;
        iss_wdata    <= '0;
        iss_mem_op   <= '0;
        iss_is_load  <= 1'b0;
        iss_unsigned <= 1'b0;
        iss_rob_idx  <= '0;
        iss_rob_gen  <= '0;
        iss_rd_tag   <= '0;
        iss_rd_is_fp <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && !q[i].base_rdy
            && cdb_valid && !cdb_is_fp
            && cdb_tag == q[i].base_tag) begin
          q[i].base_rdy <= 1'b1;
          q[i].base_val <= cdb_value;
        end
        if (q[i].valid && !q[i].data_rdy
            && cdb_valid
            && cdb_is_fp == q[i].data_fp
            && cdb_tag == q[i].data_tag) begin
          q[i].data_rdy <= 1'b1;
          q[i].data_val <= cdb_value;
        end
      end
      if (do_enq) begin
        q[tail] <= new_e;
        tail    <= tail + PW'(1);
      end
      iss_valid <= do_iss;
      if (do_iss) begin
        q[head].valid <= 1'b0;
        head          <= head + PW'(1);
        iss_addr      <= hd.base_val + hd.imm;
        iss_wdata     <= hd.data_val;
        iss_mem_op    <= hd.mem_op;
        iss_is_load   <= hd.is_load;
        iss_unsigned  <= hd.uns;
        iss_rob_idx   <= hd.rob_idx;
        iss_rob_gen   <= hd.rob_gen;
        iss_rd_tag    <= hd.rd_tag;
        iss_rd_is_fp  <= hd.rd_fp;
      end
      unique case ({do_enq, do_iss})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue.
// Hand-computed expectations, DEPTH=4.
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 4
`endif
`ifndef ROB_IDX_WIDTH
`define ROB_IDX_WIDTH 5
`endif
`ifndef ROB_GEN_WIDTH
`define ROB_GEN_WIDTH 1
`endif

module tb_mem_issue_queue;

  logic        clk = 0;
  logic        rst, flush, enq_valid, enq_ready;
  logic        enq_base_ready;
  logic [`PREG_IDX_WIDTH-1:0] enq_base_tag;
  logic [31:0] enq_base_val;
  logic        enq_data_ready;
  logic [`PREG_IDX_WIDTH-1:0] enq_data_tag;
  logic        enq_data_is_fp;
  logic [31:0] enq_data_val, enq_imm;
  logic [`MEM_OP_WIDTH-1:0] enq_mem_op;
  logic        enq_is_load, enq_unsigned;
  logic [`ROB_IDX_WIDTH-1:0] enq_rob_idx;
  logic [`ROB_GEN_WIDTH-1:0] enq_rob_gen;
  logic [`PREG_IDX_WIDTH-1:0] enq_rd_tag;
  logic        enq_rd_is_fp;
  logic        cdb_valid;
  logic [`PREG_IDX_WIDTH-1:0] cdb_tag;
  logic        cdb_is_fp;
  logic [31:0] cdb_value;
  logic        lsu_busy, iss_valid;
  logic [31:0] iss_addr, iss_wdata;
  logic [`MEM_OP_WIDTH-1:0] iss_mem_op;
  logic        iss_is_load, iss_unsigned;
  logic [`ROB_IDX_WIDTH-1:0] iss_rob_idx;
  logic [`ROB_GEN_WIDTH-1:0] iss_rob_gen;
  logic [`PREG_IDX_WIDTH-1:0] iss_rd_tag;
  logic        iss_rd_is_fp;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses;
  logic [4:0] robs [$];
  int         when [$];

  mem_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_base_ready(enq_base_ready),
    .enq_base_tag(enq_base_tag),
    .enq_base_val(enq_base_val),
    .enq_data_ready(enq_data_ready),
    .enq_data_tag(enq_data_tag),
    .enq_data_is_fp(enq_data_is_fp),
    .enq_data_val(enq_data_val),
    .enq_imm(enq_imm), .enq_mem_op(enq_mem_op),
    .enq_is_load(enq_is_load),
    .enq_unsigned(enq_unsigned),
    .enq_rob_idx(enq_rob_idx),
    .enq_rob_gen(enq_rob_gen),
    .enq_rd_tag(enq_rd_tag),
    .enq_rd_is_fp(enq_rd_is_fp),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_is_fp(cdb_is_fp), .cdb_value(cdb_value),
    .lsu_busy(lsu_busy), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_wdata(iss_wdata),
    .iss_mem_op(iss_mem_op),
    .iss_is_load(iss_is_load),
    .iss_unsigned(iss_unsigned),
    .iss_rob_idx(iss_rob_idx),
    .iss_rob_gen(iss_rob_gen),
    .iss_rd_tag(iss_rd_tag),
    .iss_rd_is_fp(iss_rd_is_fp),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cdb(input logic v,
                     input logic [5:0] t,
                     input logic fp,
                     input logic [31:0] val);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_is_fp = fp;
    cdb_value = val;
  endtask

  task automatic enq(input logic ld,
                     input logic brdy,
                     input logic [5:0] btag,
                     input logic [31:0] bval,
                     input logic drdy,
                     input logic [5:0] dtag,
                     input logic dfp,
                     input logic [31:0] dval,
                     input logic [31:0] imm,
                     input logic [4:0] rob);
    enq_valid      = 1;
    enq_is_load    = ld;
    enq_base_ready = brdy;
    enq_base_tag   = btag;
    enq_base_val   = bval;
    enq_data_ready = drdy;
    enq_data_tag   = dtag;
    enq_data_is_fp = dfp;
    enq_data_val   = dval;
    enq_imm        = imm;
    enq_rob_idx    = rob;
    enq_mem_op     = 4'(rob);
    step();
    enq_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    robs.delete();
    when.delete();
    while (!(count == 0 && !iss_valid)
           && n < 60) begin
      step();
      n++;
      if (iss_valid) begin
        robs.push_back(iss_rob_idx);
        when.push_back(cyc);
      end
    end
    chk("drain_timeout", 32'(n >= 60), 0);
  endtask

  task automatic chk_seq(input string tag,
                         input int r0,
                         input int n);
    chk({tag, "_n"}, robs.size(), n);
    for (int i = 0; i < n && i < robs.size(); i++)
      chk({tag, "_rob"}, robs[i], r0 + i);
    for (int i = 1; i < when.size(); i++)
      chk({tag, "_gap"}, when[i] - when[i-1], 2);
  endtask

  initial begin
    rst = 1; flush = 0; enq_valid = 0;
    enq_base_ready = 0; enq_base_tag = 0;
    enq_base_val = 0; enq_data_ready = 0;
    enq_data_tag = 0; enq_data_is_fp = 0;
    enq_data_val = 0; enq_imm = 0;
    enq_mem_op = 0; enq_is_load = 0;
    enq_unsigned = 0; enq_rob_idx = 0;
    enq_rob_gen = 0; enq_rd_tag = 0;
    enq_rd_is_fp = 0; lsu_busy = 0;
    cdb(0, 0, 0, 0);
    step(); step();
    rst = 0;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", iss_addr, 0);
    chk("rst_rob", iss_rob_idx, 0);

    // LW base ready
    enq(1, 1, 0, 32'h1000, 0, 0, 0, 0, 4, 1);
    chk("lw_cnt1", count, 1);
    chk("lw_nv", iss_valid, 0);
    step();
    chk("lw_v", iss_valid, 1);
    chk("lw_addr", iss_addr, 32'h1004);
    chk("lw_ld", iss_is_load, 1);
    chk("lw_rob", iss_rob_idx, 1);
    chk("lw_cnt0", count, 0);
    step();
    chk("lw_pulse", iss_valid, 0);

    // SW waiting on base tag 5
    enq(0, 0, 5, 0, 1, 0, 0, 32'hdead, 8, 2);
    step(); step();
    chk("sw_wait", iss_valid, 0);
    chk("sw_cnt", count, 1);
    cdb(1, 5, 0, 32'h2000);
    step();
    cdb(0, 0, 0, 0);
    chk("sw_nobyp", iss_valid, 0);
    step();
    chk("sw_v", iss_valid, 1);
    chk("sw_addr", iss_addr, 32'h2008);
    chk("sw_wd", iss_wdata, 32'hdead);
    chk("sw_st", iss_is_load, 0);
    step();

    // fill, head blocked on tag 7
    enq(1, 0, 7, 0, 0, 0, 0, 0, 0, 10);
    enq(1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 11);
    enq(1, 1, 0, 32'h200, 0, 0, 0, 0, 0, 12);
    enq(1, 1, 0, 32'h300, 0, 0, 0, 0, 0, 13);
    chk("full_cnt", count, 4);
    chk("full_rdy", enq_ready, 0);
    enq(1, 1, 0, 32'h400, 0, 0, 0, 0, 0, 14);
    chk("full_drop", count, 4);
    cdb(1, 7, 0, 32'h3000);
    step();
    cdb(0, 0, 0, 0);
    chk("full_rdy2", enq_ready, 0);
    step();
    chk("full_v", iss_valid, 1);
    chk("full_addr", iss_addr, 32'h3000);
    chk("full_rob", iss_rob_idx, 10);
    chk("full_rdy3", enq_ready, 1);
    chk("full_cnt3", count, 3);
    drain();
    chk_seq("full", 11, 3);

    // LSU busy holds off issue
    lsu_busy = 1;
    enq(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 20);
    enq(0, 1, 0, 32'h20, 1, 0, 0, 1, 0, 21);
    enq(1, 1, 0, 32'h30, 0, 0, 0, 0, 0, 22);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (iss_valid) pulses++;
    end
    chk("busy_none", pulses, 0);
    lsu_busy = 0;
    drain();
    chk_seq("busy", 20, 3);

    // same-cycle bypass on base
    cdb(1, 9, 0, 32'h4000);
    enq(1, 0, 9, 0, 0, 0, 0, 0, 32'h10, 3);
    cdb(0, 0, 0, 0);
    step();
    chk("byp_v", iss_valid, 1);
    chk("byp_addr", iss_addr, 32'h4010);
    step();

    // FP store data waits for an FP broadcast
    enq(0, 1, 0, 32'h5000, 0, 3, 1, 0, 0, 4);
    cdb(1, 3, 0, 32'h1111);
    step();
    cdb(0, 0, 0, 0);
    step(); step();
    chk("fp_int_nowake", iss_valid, 0);
    chk("fp_cnt", count, 1);
    cdb(1, 3, 1, 32'h2222);
    step();
    cdb(0, 0, 0, 0);
    step();
    chk("fp_v", iss_valid, 1);
    chk("fp_wd", iss_wdata, 32'h2222);
    step();

    // FP data bypass at enqueue
    cdb(1, 4, 1, 32'h7777);
    enq(0, 1, 0, 32'h60, 0, 4, 1, 0, 0, 5);
    cdb(0, 0, 0, 0);
    step();
    chk("fpbyp_v", iss_valid, 1);
    chk("fpbyp_wd", iss_wdata, 32'h7777);
    step();

    // flush with 3 entries and an issue due
    lsu_busy = 1;
    enq(1, 1, 0, 1, 0, 0, 0, 0, 0, 6);
    enq(1, 1, 0, 2, 0, 0, 0, 0, 0, 7);
    enq(1, 1, 0, 3, 0, 0, 0, 0, 0, 8);
    chk("fl_cnt3", count, 3);
    lsu_busy = 0;
    flush = 1;
    step();
    flush = 0;
    chk("fl_cnt", count, 0);
    chk("fl_v", iss_valid, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (iss_valid) pulses++;
    end
    chk("fl_none", pulses, 0);

    // simultaneous enq and issue
    enq(1, 1, 0, 32'h80, 0, 0, 0, 0, 0, 1);
    enq(1, 1, 0, 32'h90, 0, 0, 0, 0, 0, 2);
    chk("sim_cnt", count, 1);
    chk("sim_v", iss_valid, 1);
    chk("sim_addr", iss_addr, 32'h80);
    drain();
    chk_seq("sim", 2, 1);

    // wrap: 10 enq/issue pairs
    for (int i = 0; i < 10; i++) begin
      enq(1, 1, 0, 32'(i * 32'h100), 0, 0,
          0, 0, 32'(i), 5'(i + 16));
      step();
      chk("wrap_v", iss_valid, 1);
      chk("wrap_addr", iss_addr,
          32'(i * 32'h101));
      chk("wrap_rob", iss_rob_idx, i + 16);
      step();
    end
    chk("wrap_cnt", count, 0);

    // negative offset and 32-bit wrap
    enq(1, 1, 0, 32'h100, 0, 0, 0, 0,
        32'hffff_fff0, 9);
    step();
    chk("neg_addr", iss_addr, 32'hf0);
    step();
    enq(1, 1, 0, 32'hffff_fffc, 0, 0, 0, 0,
        32'h8, 9);
    step();
    chk("ovf_addr", iss_addr, 32'h4);
    step();

    // reset clears data registers
    rst = 1;
    step();
    rst = 0;
    chk("rst2_addr", iss_addr, 0);
    chk("rst2_rob", iss_rob_idx, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order memory-op issue queue sitting directly upstream of the load/store unit. Holds dispatched loads/stores until their base-address and store-data operands are produced on the CDB, computes the effective address and issues one op at a time to the LSU in program order. Stores are never reordered past loads, so the LSU sees memory ops exactly in dispatch order.

## Interface
- DEPTH, 4, entry count; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  drop all entries and any pending issue
- enq_valid  in  1  dispatch presents a memory op
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_base_ready / enq_base_tag / enq_base_val  in  1/`PREG_IDX_WIDTH/32  rs1 (always int)
- enq_data_ready / enq_data_tag / enq_data_is_fp / enq_data_val  in  1/`PREG_IDX_WIDTH/1/32  store data (ignored for loads: treated ready)
- enq_imm  in  32  sign-extended offset
- enq_mem_op, enq_is_load, enq_unsigned, enq_rob_idx, enq_rob_gen, enq_rd_tag, enq_rd_is_fp  in  `MEM_OP_WIDTH/1/1/`ROB_IDX_WIDTH/`ROB_GEN_WIDTH/`PREG_IDX_WIDTH/1  op fields
- cdb_valid / cdb_tag / cdb_is_fp / cdb_value  in  1/`PREG_IDX_WIDTH/1/32  result broadcast
- lsu_busy  in  1  LSU not in IDLE
- iss_valid  out  1  one-cycle issue pulse to LSU valid_in
- iss_addr, iss_wdata  out  32  base+imm, store data
- iss_mem_op, iss_is_load, iss_unsigned, iss_rob_idx, iss_rob_gen, iss_rd_tag, iss_rd_is_fp  out  op fields, registered
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer, head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy.
- Enqueue when enq_valid && enq_ready: write entry at tail, tail+1, count+1.
- Wakeup: every valid entry with operand not ready and tag match (cdb_valid, tag equal, is_fp equal; base requires cdb_is_fp=0) captures cdb_value and sets ready.
- Enqueue bypass: if an enqueuing operand is not ready and matches the CDB this cycle, it is stored ready with cdb_value.
- Issue condition (cycle t): head valid, base ready, data ready (or is_load), !lsu_busy, !iss_valid. On issue: output registers load at edge end of t (iss_addr = base_val + imm, mod 2^32), iss_valid=1 for cycle t+1 only, head+1, count-1, entry invalidated.
- The !iss_valid term covers the cycle before LSU asserts busy; at most one issue every 2 cycles.
- Simultaneous enq and issue: both occur; count unchanged. enq_ready uses current count only (full queue does not accept even if issuing).
- Issue uses stored operand values only; a CDB wakeup of head in cycle t allows issue at t+1 earliest.
- flush: all entries invalid, head=tail=0, count=0, iss_valid=0 next cycle; enqueue and issue in flush cycle suppressed. flush has priority over everything but rst.
- rst: same as flush, plus all iss_* data registers 0.

## Timing
- Reset values: enq_ready=1, iss_valid=0, all iss_* =0, count=0.
- Enqueue to issue minimum latency: entry written at edge t→t+1, issue decision t+1, iss_valid high at t+2.
- enq_ready combinational from count; iss_* all registered.
- Back-to-back ready ops with LSU instantly idle: iss_valid at t, t+2, t+4 ...
- Misaligned op (LSU stays IDLE): next op may issue 2 cycles after previous pulse.

## Test plan
- Reset then enqueue LW, base ready=0x1000, imm=4 -> iss_valid 2 cycles later, iss_addr=0x1004, count returns to 0.
- Enqueue SW with base tag 5 not ready -> no issue; cdb_valid tag 5 value 0x2000 -> issue next cycle+1, iss_addr=0x2000+imm.
- Fill DEPTH=4 entries, head not ready -> enq_ready=0, count=4; wake head -> issue, enq_ready=1 following cycle.
- Three ready ops, lsu_busy held 1 for 10 cycles -> no iss_valid; release -> issues in order with ≥1-cycle gap, rob_idx sequence preserved.
- Enqueue with operand tag matching same-cycle CDB -> captured ready, issues without further broadcast; FP store data tag only matches cdb_is_fp=1.
- Flush with 3 entries and iss_valid pending -> count=0, iss_valid=0 next cycle, no later issue; wrap test: 10 enq/issue pairs, pointers wrap, addresses correct.
